// File: rtl/bram_stream_reader_pkg.sv
// Shared types and default sizing for the BRAM burst reader.
// Imported by the reader top; the interface uses qualified defaults.
package bram_stream_reader_pkg;

  localparam int DATA_W_D     = 128;
  localparam int ADDR_W_D     = 10;
  localparam int RD_LAT_D     = 1;
  localparam int FIFO_DEPTH_D = 4;
  localparam int LEN_W_D      = 11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM port-B and output stream signals of the reader.
// slave = reader side, master = environment side.
interface bram_stream_reader_if #(
  parameter int DATA_W = bram_stream_reader_pkg::DATA_W_D,
  parameter int ADDR_W = bram_stream_reader_pkg::ADDR_W_D,
  parameter int LEN_W  = bram_stream_reader_pkg::LEN_W_D
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_base, cmd_len,
    input  doutb, out_ready,
    output cmd_ready, enb, addrb,
    output out_valid, out_data, out_last,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_base, cmd_len,
    output doutb, out_ready,
    input  cmd_ready, enb, addrb,
    input  out_valid, out_data, out_last,
    input  busy, done
  );

endinterface

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO holding {last, data} words from the BRAM.
// Head word is presented straight from the storage registers.
module bram_rd_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          rd_go;

  assign rd_valid = cnt != '0;
  assign rd_go    = rd_en && rd_valid;
  assign rd_data  = rd_valid ? mem[rp] : '0;
  assign count    = cnt;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + PW'(1);
      if (rd_go) rp <= rp + PW'(1);
      unique case ({wr_en, rd_go})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader for one BRAM read port: issues credited reads,
// absorbs the read latency and emits a valid/ready stream.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int RD_LATENCY = RD_LAT_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int LEN_W      = LEN_W_D
) (
  input  logic clock,
  input  logic reset,
  bram_stream_reader_if.slave bus
);

  localparam int CW = cnt_w(FIFO_DEPTH);

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0]     cur;
  logic [LEN_W-1:0]      left;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           used;
  logic [RD_LATENCY-1:0] pv;
  logic [RD_LATENCY-1:0] pl;
  logic [DATA_W:0]       rd_word;
  logic                  hs;
  logic                  credit;
  logic                  issue;
  logic                  last_issue;
  logic                  last_pop;
  logic                  busy_q;
  logic                  done_q;

  assign bus.cmd_ready = (state == IDLE) && !reset;
  assign hs            = bus.cmd_valid && bus.cmd_ready;

  // Reads still in the latency pipe count against buffer space.
  assign used   = {1'b0, in_flight} + {1'b0, fifo_cnt};
  assign credit = used < (CW+1)'(FIFO_DEPTH);

  assign issue      = (state == ISSUE) && credit;
  assign last_issue = issue && (left == LEN_W'(1));
  assign last_pop   = bus.out_valid && bus.out_ready
                   && bus.out_last;

  assign bus.enb   = issue;
  assign bus.addrb = cur;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign {bus.out_last, bus.out_data} = rd_word;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (hs && bus.cmd_len != '0) state_n = ISSUE;
      ISSUE: if (last_issue) state_n = DRAIN;
      DRAIN: if (last_pop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      left      <= '0;
      in_flight <= '0;
      pv        <= '0;
      pl        <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (hs) begin
        cur  <= bus.cmd_base;
        left <= bus.cmd_len;
      end else if (issue) begin
        cur  <= cur + ADDR_W'(1);
        left <= left - LEN_W'(1);
      end
      pv[0] <= issue;
      pl[0] <= last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end
      unique case (1'b1)
        issue && !pv[RD_LATENCY-1]:
          in_flight <= in_flight + CW'(1);
        !issue && pv[RD_LATENCY-1]:
          in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
      done_q <= (hs && bus.cmd_len == '0)
             || (state == DRAIN && last_pop);
      if (hs && bus.cmd_len != '0)
        busy_q <= 1'b1;
      else if (state == DRAIN && last_pop)
        busy_q <= 1'b0;
    end
  end

  bram_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (pv[RD_LATENCY-1]),
    .wr_data  ({pl[RD_LATENCY-1], bus.doutb}),
    .rd_en    (bus.out_ready),
    .rd_data  (rd_word),
    .rd_valid (bus.out_valid),
    .count    (fifo_cnt)
  );

endmodule
